// File: rtl/hsv_core_issue_scoreboard.sv
// Register-hazard scoreboard between issue masking and dispatch: tracks in-flight
// writers, stalls hazardous issue and drives a one-entry valid/ready output register.
package hsv_core_issue_pkg;
  typedef logic [30:0] reg_mask;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } issue_data_t;
endpackage

module hsv_core_issue_scoreboard
  import hsv_core_issue_pkg::*;
#(
  parameter int MAX_INFLIGHT  = 8,
  parameter int CNT_W         = $clog2(MAX_INFLIGHT + 1),
  parameter bit COMMIT_BYPASS = 1'b1
) (
  input  logic             clk_core,
  input  logic             rst_core_n,
  input  logic             flush_req,
  input  logic             valid_i,
  input  issue_data_t      issue_data,
  input  reg_mask          mask,
  input  reg_mask          rd_mask,
  output logic             stall_o,
  output issue_data_t      out,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             commit_valid,
  input  reg_mask          commit_mask,
  output reg_mask          busy_o,
  output logic [CNT_W-1:0] inflight_o
);

  reg_mask          busy_r;
  reg_mask          clr_s;
  reg_mask          busy_eff_s;
  logic [CNT_W-1:0] inflight_r;
  logic [CNT_W-1:0] cnt_cmp_s;
  issue_data_t      out_r;
  logic             valid_r;
  logic             hazard_s;
  logic             full_s;
  logic             blocked_s;
  logic             stall_s;
  logic             fire_s;
  logic             inc_s;
  logic             dec_s;

  // Hazard, capacity and accept decode for the instruction presented this cycle
  always_comb begin
    clr_s      = 31'd0;
    busy_eff_s = busy_r;
    cnt_cmp_s  = inflight_r;
    if (commit_valid) begin
      clr_s = commit_mask & busy_r;
    end else begin
      clr_s = 31'd0;
    end
    // With bypass a retiring writer no longer blocks, and frees its counter slot now
    if (COMMIT_BYPASS && (clr_s != 31'd0)) begin
      busy_eff_s = busy_r & ~clr_s;
      cnt_cmp_s  = inflight_r - CNT_W'(1);
    end else begin
      busy_eff_s = busy_r;
      cnt_cmp_s  = inflight_r;
    end
    hazard_s  = |(mask & busy_eff_s);
    full_s    = (cnt_cmp_s == CNT_W'(MAX_INFLIGHT)) && (rd_mask != 31'd0);
    blocked_s = valid_r & ~ready_i;
    stall_s   = valid_i & (hazard_s | full_s | blocked_s | flush_req);
    fire_s    = valid_i & ~stall_s;
    inc_s     = fire_s & (rd_mask != 31'd0);
    dec_s     = (clr_s != 31'd0);
  end

  // Busy vector, in-flight counter and output register state
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      busy_r     <= 31'd0;
      inflight_r <= CNT_W'(0);
      valid_r    <= 1'b0;
      out_r      <= issue_data_t'(64'd0);
    end else if (flush_req) begin
      busy_r     <= 31'd0;
      inflight_r <= CNT_W'(0);
      valid_r    <= 1'b0;
    end else begin
      // A new writer wins over a same-cycle retirement of the same register
      busy_r <= (busy_r & ~clr_s) | (fire_s ? rd_mask : 31'd0);
      case ({inc_s, dec_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
      if (fire_s) begin
        out_r   <= issue_data;
        valid_r <= 1'b1;
      end else if (ready_i || !valid_r) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign stall_o    = stall_s;
  assign out        = out_r;
  assign valid_o    = valid_r;
  assign busy_o     = busy_r;
  assign inflight_o = inflight_r;

endmodule

// Input-legality properties for the scoreboard interface.
module hsv_core_issue_scoreboard_chk
  import hsv_core_issue_pkg::*;
(
  input logic    clk,
  input logic    rst_n,
  input logic    valid_i,
  input reg_mask mask,
  input reg_mask rd_mask,
  input reg_mask commit_mask
);
  a_commit_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(commit_mask) <= 1) else $error("commit_mask has more than one bit set");
  a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(rd_mask) <= 1) else $error("rd_mask has more than one bit set");
  a_rd_in_mask: assert property (@(posedge clk) disable iff (!rst_n)
    valid_i |-> ((rd_mask & ~mask) == 31'd0)) else $error("rd_mask not contained in mask");
endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// Bench for hsv_core_issue_scoreboard: directed vector table plus randomized traffic,
// with a bypass and a non-bypass instance each checked against a register-set model.
module tb_hsv_core_issue_scoreboard;
  import hsv_core_issue_pkg::*;

  localparam int MAXF = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid_i, ready, cv;
  issue_data_t din;
  reg_mask     mask, rd_mask, cm;
  logic        stall_a, stall_b, valid_a, valid_b;
  issue_data_t out_a, out_b;
  reg_mask     busy_a, busy_b;
  logic [2:0]  infl_a, infl_b;

  int checks = 0;
  int errors = 0;

  bit          mbusy [2][1:31];
  bit          mvalid [2];
  issue_data_t mout [2];

  always #5 clk = ~clk;

  hsv_core_issue_scoreboard #(.MAX_INFLIGHT(MAXF), .COMMIT_BYPASS(1'b1)) dut_a (
    .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush), .valid_i(valid_i),
    .issue_data(din), .mask(mask), .rd_mask(rd_mask), .stall_o(stall_a), .out(out_a),
    .valid_o(valid_a), .ready_i(ready), .commit_valid(cv), .commit_mask(cm),
    .busy_o(busy_a), .inflight_o(infl_a));

  hsv_core_issue_scoreboard #(.MAX_INFLIGHT(MAXF), .COMMIT_BYPASS(1'b0)) dut_b (
    .clk_core(clk), .rst_core_n(rst_n), .flush_req(flush), .valid_i(valid_i),
    .issue_data(din), .mask(mask), .rd_mask(rd_mask), .stall_o(stall_b), .out(out_b),
    .valid_o(valid_b), .ready_i(ready), .commit_valid(cv), .commit_mask(cm),
    .busy_o(busy_b), .inflight_o(infl_b));

  hsv_core_issue_scoreboard_chk u_chk (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mask(mask), .rd_mask(rd_mask),
    .commit_mask(cm));

  typedef struct {
    bit rst_n, flush, v; reg_mask m, rd; bit rdy, cv; reg_mask cm; logic [31:0] pc;
    bit e_stall, e_valid; reg_mask e_busy; int e_infl; logic [31:0] e_pc;
    bit chk_nb, e_stall_nb;
  } vec_t;

  vec_t tab [24];

  function automatic issue_data_t mkd(input logic [31:0] pc);
    mkd = {pc, pc * 32'd7};
  endfunction

  function automatic reg_mask oh(input int r);
    oh = (r == 0) ? 31'd0 : (31'd1 << (r - 1));
  endfunction

  function automatic vec_t mk(input bit r, f, v, input reg_mask m, rd, input bit rdy, c,
                              input reg_mask cmk, input logic [31:0] pc, input bit es, ev,
                              input reg_mask eb, input int ei, input logic [31:0] ep,
                              input bit cn, esn);
    vec_t t;
    t.rst_n = r; t.flush = f; t.v = v; t.m = m; t.rd = rd; t.rdy = rdy; t.cv = c;
    t.cm = cmk; t.pc = pc; t.e_stall = es; t.e_valid = ev; t.e_busy = eb; t.e_infl = ei;
    t.e_pc = ep; t.chk_nb = cn; t.e_stall_nb = esn;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rst_n; flush = t.flush; valid_i = t.v; mask = t.m; rd_mask = t.rd;
    ready = t.rdy; cv = t.cv; cm = t.cm; din = mkd(t.pc);
  endtask

  // Reference: busy registers as a set, inflight as the size of that set
  task automatic model_step();
    int clr, cnt, rdi, eff;
    bit haz, full, es, fire, byp;
    reg_mask pk;
    string tag;
    for (int p = 0; p < 2; p++) begin
      byp = (p == 0); tag = byp ? "byp" : "nb";
      clr = 0; cnt = 0; rdi = 0; haz = 1'b0; pk = 31'd0;
      for (int r = 1; r <= 31; r++) begin
        if (mbusy[p][r]) begin cnt++; pk[r-1] = 1'b1; end
        if (cv && cm[r-1] && mbusy[p][r]) clr = r;
        if (rd_mask[r-1]) rdi = r;
      end
      for (int r = 1; r <= 31; r++)
        if (mask[r-1] && mbusy[p][r] && !(byp && r == clr)) haz = 1'b1;
      eff  = (byp && clr != 0) ? cnt - 1 : cnt;
      full = (eff == MAXF) && (rdi != 0);
      es   = valid_i && (haz || full || (mvalid[p] && !ready) || flush);
      fire = valid_i && !es;
      check({tag, "_stall"}, 64'(byp ? stall_a : stall_b), 64'(es));
      check({tag, "_valid"}, 64'(byp ? valid_a : valid_b), 64'(mvalid[p]));
      check({tag, "_out"}, 64'(byp ? out_a : out_b), 64'(mout[p]));
      check({tag, "_busy"}, 64'(byp ? busy_a : busy_b), 64'(pk));
      check({tag, "_inflight"}, 64'(byp ? infl_a : infl_b), 64'(cnt));
      if (!rst_n) begin
        for (int r = 1; r <= 31; r++) mbusy[p][r] = 1'b0;
        mvalid[p] = 1'b0; mout[p] = issue_data_t'(64'd0);
      end else if (flush) begin
        for (int r = 1; r <= 31; r++) mbusy[p][r] = 1'b0;
        mvalid[p] = 1'b0;
      end else begin
        if (clr != 0) mbusy[p][clr] = 1'b0;
        if (fire) begin
          if (rdi != 0) mbusy[p][rdi] = 1'b1;
          mout[p] = din; mvalid[p] = 1'b1;
        end else if (ready || !mvalid[p]) begin
          mvalid[p] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int rs1, rs2, rd;
    //            rst f v mask      rd       rdy cv cm      pc | stall vld busy      infl pc  nb  stall_nb
    tab[0]  = mk(0, 0, 1, 31'h10, 31'h10, 1, 0, 31'h0, 32'd1,  0, 0, 31'h00, 0, 32'd0, 0, 0);
    tab[1]  = mk(0, 0, 1, 31'h10, 31'h10, 1, 0, 31'h0, 32'd1,  0, 0, 31'h00, 0, 32'd0, 0, 0);
    tab[2]  = mk(1, 0, 1, 31'h10, 31'h10, 1, 0, 31'h0, 32'd1,  0, 0, 31'h00, 0, 32'd0, 0, 0);
    tab[3]  = mk(1, 0, 1, 31'h11, 31'h0,  1, 0, 31'h0, 32'd2,  1, 1, 31'h10, 1, 32'd1, 0, 0);
    tab[4]  = mk(1, 0, 1, 31'h11, 31'h0,  1, 0, 31'h0, 32'd2,  1, 0, 31'h10, 1, 32'd1, 0, 0);
    tab[5]  = mk(1, 0, 1, 31'h11, 31'h0,  1, 0, 31'h0, 32'd2,  1, 0, 31'h10, 1, 32'd1, 0, 0);
    tab[6]  = mk(1, 0, 1, 31'h11, 31'h0,  1, 1, 31'h10, 32'd2, 0, 0, 31'h10, 1, 32'd1, 1, 1);
    tab[7]  = mk(1, 0, 1, 31'h11, 31'h0,  1, 0, 31'h0, 32'd2,  0, 1, 31'h00, 0, 32'd2, 1, 0);
    tab[8]  = mk(1, 0, 1, 31'h10, 31'h10, 1, 0, 31'h0, 32'd3,  0, 1, 31'h00, 0, 32'd2, 0, 0);
    tab[9]  = mk(1, 0, 1, 31'h20, 31'h20, 1, 0, 31'h0, 32'd4,  0, 1, 31'h10, 1, 32'd3, 0, 0);
    tab[10] = mk(1, 0, 0, 31'h0,  31'h0,  1, 0, 31'h0, 32'd0,  0, 1, 31'h30, 2, 32'd4, 0, 0);
    tab[11] = mk(1, 0, 1, 31'h1,  31'h1,  1, 0, 31'h0, 32'd5,  0, 0, 31'h30, 2, 32'd4, 0, 0);
    for (int i = 12; i <= 16; i++)
      tab[i] = mk(1, 0, 1, 31'h2, 31'h2,  0, 0, 31'h0, 32'd6,  1, 1, 31'h31, 3, 32'd5, 0, 0);
    tab[17] = mk(1, 0, 1, 31'h2,  31'h2,  1, 0, 31'h0, 32'd6,  0, 1, 31'h31, 3, 32'd5, 0, 0);
    tab[18] = mk(1, 0, 1, 31'h40, 31'h40, 1, 0, 31'h0, 32'd7,  1, 1, 31'h33, 4, 32'd6, 0, 0);
    tab[19] = mk(1, 0, 1, 31'h40, 31'h40, 1, 1, 31'h1, 32'd7,  0, 0, 31'h33, 4, 32'd6, 1, 1);
    tab[20] = mk(1, 0, 1, 31'h4,  31'h0,  1, 0, 31'h0, 32'd9,  0, 1, 31'h72, 4, 32'd7, 0, 0);
    tab[21] = mk(1, 1, 1, 31'h4,  31'h4,  1, 1, 31'h2, 32'd8,  1, 1, 31'h72, 4, 32'd9, 0, 0);
    tab[22] = mk(1, 0, 0, 31'h0,  31'h0,  1, 0, 31'h0, 32'd0,  0, 0, 31'h00, 0, 32'd9, 0, 0);
    tab[23] = mk(1, 0, 1, 31'h4,  31'h4,  1, 0, 31'h0, 32'd10, 0, 0, 31'h00, 0, 32'd9, 0, 0);

    drive(tab[0]);
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      for (int r = 1; r <= 31; r++) mbusy[p][r] = 1'b0;
      mvalid[p] = 1'b0; mout[p] = issue_data_t'(64'd0);
    end

    for (int i = 0; i < 24; i++) begin
      drive(tab[i]);
      @(negedge clk);
      check($sformatf("tab%0d_stall", i), 64'(stall_a), 64'(tab[i].e_stall));
      check($sformatf("tab%0d_valid", i), 64'(valid_a), 64'(tab[i].e_valid));
      check($sformatf("tab%0d_busy", i), 64'(busy_a), 64'(tab[i].e_busy));
      check($sformatf("tab%0d_inflight", i), 64'(infl_a), 64'(tab[i].e_infl));
      check($sformatf("tab%0d_out", i), 64'(out_a),
            64'((tab[i].e_pc == 32'd0) ? issue_data_t'(64'd0) : mkd(tab[i].e_pc)));
      if (tab[i].chk_nb)
        check($sformatf("tab%0d_stall_nb", i), 64'(stall_b), 64'(tab[i].e_stall_nb));
      model_step();
      @(posedge clk); #1;
    end

    for (int n = 0; n < 2000; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      ready   = ($urandom_range(0, 3) != 0);
      rs1 = $urandom_range(0, 8); rs2 = $urandom_range(0, 8); rd = $urandom_range(0, 8);
      mask    = oh(rs1) | oh(rs2) | oh(rd);
      rd_mask = oh(rd);
      cv      = ($urandom_range(0, 1) != 0);
      cm      = oh($urandom_range(0, 8));
      din     = {$urandom, $urandom};
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
